// File: rtl/io_responder_pkg.sv
// Shared constants for the memory-mapped I/O responder: slot map, status bit
// positions and default FIFO sizing.
package io_responder_pkg;

    localparam int unsigned FIFO_AW_DEFAULT = 4;

    localparam logic [2:0] IO_SLOT_DATA = 3'd0;
    localparam logic [2:0] IO_SLOT_STAT = 3'd1;
    localparam logic [2:0] IO_SLOT_DONE = 3'd2;
    localparam logic [2:0] IO_SLOT_RSVD = 3'd3;
    localparam logic [2:0] IO_SLOT_CNT0 = 3'd4;
    localparam logic [2:0] IO_SLOT_CNT1 = 3'd5;
    localparam logic [2:0] IO_SLOT_CNT2 = 3'd6;
    localparam logic [2:0] IO_SLOT_CNT3 = 3'd7;

    localparam int unsigned ST_RX_NONEMPTY = 0;
    localparam int unsigned ST_TX_FULL     = 1;
    localparam int unsigned ST_RX_OVF      = 2;
    localparam int unsigned ST_TX_OVF      = 3;
    localparam int unsigned ST_DONE        = 4;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO, depth 2**AW. Pointers carry an extra wrap bit so full and
// empty fall out of a pointer compare; a pop frees room for a same-cycle push.
module io_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2**AW];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    // Gate the head so nothing stale or uninitialised leaks out while empty.
    assign head    = empty ? '0 : mem[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop_ok)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/io_responder.sv
// Byte-wide I/O responder: UART TX/RX FIFOs, sticky status flags, done flag and
// a snapshot-consistent 32-bit cycle counter, read back with one-cycle latency.
module io_responder
    import io_responder_pkg::*;
#(
    parameter int unsigned FIFO_AW = FIFO_AW_DEFAULT
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       en_in,
    input  logic       r_nw_in,
    input  logic [2:0] a_in,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       done_out
);

    logic        rd, wr;
    logic        tx_push, tx_pop, tx_full, tx_empty;
    logic        rx_pop, rx_full, rx_empty;
    logic [7:0]  rx_head;
    logic [7:0]  d_q, d_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] snap_q, snap_d;
    logic        tx_ovf_q, tx_ovf_d;
    logic        rx_ovf_q, rx_ovf_d;
    logic        done_q, done_d;
    logic [7:0]  status;

    assign rd = en_in && r_nw_in;
    assign wr = en_in && !r_nw_in;

    assign tx_push  = wr && (a_in == IO_SLOT_DATA);
    assign tx_pop   = tx_valid && tx_ready;
    assign tx_valid = !tx_empty;
    assign rx_pop   = rd && (a_in == IO_SLOT_DATA) && !rx_empty;

    io_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_tx_fifo (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (d_in),
        .head  (tx_data),
        .full  (tx_full),
        .empty (tx_empty)
    );

    io_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_rx_fifo (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .push  (rx_valid),
        .pop   (rx_pop),
        .wdata (rx_data),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_comb begin
        status                 = '0;
        status[ST_RX_NONEMPTY] = !rx_empty;
        status[ST_TX_FULL]     = tx_full;
        status[ST_RX_OVF]      = rx_ovf_q;
        status[ST_TX_OVF]      = tx_ovf_q;
        status[ST_DONE]        = done_q;
    end

    always_comb begin
        d_d      = d_q;
        snap_d   = snap_q;
        cnt_d    = cnt_q + 32'd1;
        done_d   = done_q;
        tx_ovf_d = tx_ovf_q;
        rx_ovf_d = rx_ovf_q;

        if (wr && (a_in == IO_SLOT_STAT)) begin
            if (d_in[ST_TX_OVF]) tx_ovf_d = 1'b0;
            if (d_in[ST_RX_OVF]) rx_ovf_d = 1'b0;
        end
        // Set is evaluated after the W1C so a same-cycle overflow wins.
        if (tx_push && tx_full && !tx_pop)   tx_ovf_d = 1'b1;
        if (rx_valid && rx_full && !rx_pop)  rx_ovf_d = 1'b1;
        if (wr && (a_in == IO_SLOT_DONE))    done_d   = 1'b1;
        if (wr && (a_in == IO_SLOT_CNT0))    cnt_d    = '0;

        if (rd) begin
            case (a_in)
                IO_SLOT_DATA: d_d = rx_empty ? 8'h00 : rx_head;
                IO_SLOT_STAT: d_d = status;
                IO_SLOT_DONE: d_d = {7'b0, done_q};
                IO_SLOT_RSVD: d_d = 8'h00;
                IO_SLOT_CNT0: begin
                    d_d    = cnt_q[7:0];
                    snap_d = cnt_q;
                end
                IO_SLOT_CNT1: d_d = snap_q[15:8];
                IO_SLOT_CNT2: d_d = snap_q[23:16];
                IO_SLOT_CNT3: d_d = snap_q[31:24];
                default:      d_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            d_q      <= 8'h00;
            cnt_q    <= '0;
            snap_q   <= '0;
            done_q   <= 1'b0;
            tx_ovf_q <= 1'b0;
            rx_ovf_q <= 1'b0;
        end else begin
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            snap_q   <= snap_d;
            done_q   <= done_d;
            tx_ovf_q <= tx_ovf_d;
            rx_ovf_q <= rx_ovf_d;
        end
    end

    assign d_out    = d_q;
    assign done_out = done_q;

endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder: table of bus accesses plus directed
// sequences for FIFO, overflow, reset and counter snapshot corners.
module tb_io_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, r_nw;
    logic [2:0] a;
    logic [7:0] d_in, d_out, tx_data, rx_data;
    logic       tx_valid, tx_ready, rx_valid, done_out;

    int n_total = 0;
    int n_pass  = 0;
    logic [7:0] sb_q [$];
    logic [7:0] txq [$];

    typedef struct packed {
        logic       r_nw;
        logic [2:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    io_responder #(.FIFO_AW(4)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .en_in    (en),
        .r_nw_in  (r_nw),
        .a_in     (a),
        .d_in     (d_in),
        .d_out    (d_out),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .done_out (done_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic wr(input logic [2:0] slot, input logic [7:0] data);
        @(negedge clk);
        en = 1'b1; r_nw = 1'b0; a = slot; d_in = data;
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    // Expected value queued at issue, popped when d_out is valid.
    task automatic rd(input logic [2:0] slot, input logic [7:0] exp, input string name);
        sb_q.push_back(exp);
        @(negedge clk);
        en = 1'b1; r_nw = 1'b1; a = slot;
        @(posedge clk); #1;
        en = 1'b0;
        chk(name, {24'h0, d_out}, {24'h0, sb_q.pop_front()});
    endtask

    task automatic rx_pulse(input logic [7:0] data);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = data;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic tx_pulse();
        @(negedge clk);
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
    endtask

    vec_t vecs [12];

    initial begin
        rst_n = 1'b0; en = 1'b0; r_nw = 1'b1; a = '0; d_in = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;

        // Basic slot map, done flag and counter snapshot immediately after a clear.
        vecs[0]  = '{r_nw: 1'b1, a: 3'd1, d: 8'h00, exp: 8'h00};
        vecs[1]  = '{r_nw: 1'b1, a: 3'd0, d: 8'h00, exp: 8'h00};
        vecs[2]  = '{r_nw: 1'b1, a: 3'd3, d: 8'h00, exp: 8'h00};
        vecs[3]  = '{r_nw: 1'b0, a: 3'd3, d: 8'hFF, exp: 8'h00};
        vecs[4]  = '{r_nw: 1'b1, a: 3'd3, d: 8'h00, exp: 8'h00};
        vecs[5]  = '{r_nw: 1'b1, a: 3'd2, d: 8'h00, exp: 8'h00};
        vecs[6]  = '{r_nw: 1'b0, a: 3'd4, d: 8'h00, exp: 8'h00};
        vecs[7]  = '{r_nw: 1'b1, a: 3'd4, d: 8'h00, exp: 8'h00};
        vecs[8]  = '{r_nw: 1'b1, a: 3'd5, d: 8'h00, exp: 8'h00};
        vecs[9]  = '{r_nw: 1'b0, a: 3'd2, d: 8'h01, exp: 8'h00};
        vecs[10] = '{r_nw: 1'b1, a: 3'd2, d: 8'h00, exp: 8'h01};
        vecs[11] = '{r_nw: 1'b1, a: 3'd1, d: 8'h00, exp: 8'h10};

        #12;
        chk("reset d_out", {24'h0, d_out}, 32'h0);
        chk("reset tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("reset tx_data", {24'h0, tx_data}, 32'h0);
        chk("reset done_out", {31'h0, done_out}, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].r_nw) rd(vecs[i].a, vecs[i].exp, $sformatf("vec[%0d]", i));
            else              wr(vecs[i].a, vecs[i].d);
        end
        chk("done_out set", {31'h0, done_out}, 32'h1);

        // Reset in the middle of traffic with a read in flight.
        wr(3'd0, 8'h33);
        rx_pulse(8'h44);
        @(negedge clk);
        en = 1'b1; r_nw = 1'b1; a = 3'd2;
        @(posedge clk); #2;
        rst_n = 1'b0; en = 1'b0;
        #1;
        chk("midrst d_out", {24'h0, d_out}, 32'h0);
        chk("midrst tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("midrst done_out", {31'h0, done_out}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        rd(3'd1, 8'h00, "post-reset status");
        rd(3'd0, 8'h00, "post-reset rx empty");

        // TX path.
        wr(3'd0, 8'h41);
        chk("tx_valid after push", {31'h0, tx_valid}, 32'h1);
        wr(3'd0, 8'h42);
        chk("tx_data head", {24'h0, tx_data}, 32'h41);
        tx_pulse();
        chk("tx_data after pop", {24'h0, tx_data}, 32'h42);
        tx_pulse();
        chk("tx drained", {31'h0, tx_valid}, 32'h0);

        // TX overflow: 17th byte dropped.
        for (int i = 0; i < 17; i++) begin
            wr(3'd0, 8'(8'h10 + i));
            if (i < 16) txq.push_back(8'(8'h10 + i));
        end
        rd(3'd1, 8'h0A, "tx ovf status");
        wr(3'd1, 8'h08);
        rd(3'd1, 8'h02, "tx ovf cleared");
        for (int i = 0; i < 20 && txq.size() > 0; i++) begin
            chk($sformatf("tx drain[%0d]", i), {24'h0, tx_data}, {24'h0, txq.pop_front()});
            tx_pulse();
        end
        chk("tx drain count", txq.size(), 32'd0);
        chk("tx empty after drain", {31'h0, tx_valid}, 32'h0);

        // RX path.
        rx_pulse(8'h5A);
        rd(3'd1, 8'h01, "rx nonempty");
        rd(3'd0, 8'h5A, "rx pop");
        rd(3'd0, 8'h00, "rx empty read");
        rd(3'd1, 8'h00, "rx status empty");

        // RX full with same-cycle push and pop: no overflow, stays full.
        for (int i = 0; i < 16; i++) rx_pulse(8'(8'h80 + i));
        rd(3'd1, 8'h01, "rx full status");
        sb_q.push_back(8'h80);
        @(negedge clk);
        en = 1'b1; r_nw = 1'b1; a = 3'd0; rx_valid = 1'b1; rx_data = 8'hEE;
        @(posedge clk); #1;
        en = 1'b0; rx_valid = 1'b0;
        chk("rx full push+pop", {24'h0, d_out}, {24'h0, sb_q.pop_front()});
        rd(3'd1, 8'h01, "rx no ovf");
        rx_pulse(8'h77);
        rd(3'd1, 8'h05, "rx ovf set");
        for (int i = 1; i < 16; i++) rd(3'd0, 8'(8'h80 + i), $sformatf("rx drain[%0d]", i));
        rd(3'd0, 8'hEE, "rx simultaneous byte");
        rd(3'd0, 8'h00, "rx drained");
        wr(3'd1, 8'h04);
        rd(3'd1, 8'h00, "rx ovf cleared");

        // Counter snapshot: cleared at write edge, read 301 edges later sees 300.
        wr(3'd4, 8'h00);
        repeat (300) @(posedge clk);
        rd(3'd4, 8'h2C, "cnt byte0");
        rd(3'd5, 8'h01, "cnt byte1");
        rd(3'd6, 8'h00, "cnt byte2");
        rd(3'd7, 8'h00, "cnt byte3");
        repeat (20) @(posedge clk);
        rd(3'd5, 8'h01, "snap stable");

        wr(3'd2, 8'h00);
        chk("done_out final", {31'h0, done_out}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
